// File: rtl/pc_next_unit_if.sv
// Control/status bundle between the control path and the PC stage.
// The control side drives redirect/stall/halt; the PC stage returns PC state.
interface pc_next_unit_if #(
   parameter int CNT_W = 32
);
   logic             pc_src;
   logic             jump;
   logic [31:0]      imm_ext;
   logic [25:0]      jump_addr;
   logic             stall;
   logic             halt;
   logic [31:0]      pc_out;
   logic [31:0]      pc_plus4;
   logic             pc_valid;
   logic             halted;
   logic [CNT_W-1:0] fetch_cnt;

   modport master (
      output pc_src, jump, imm_ext, jump_addr, stall, halt,
      input  pc_out, pc_plus4, pc_valid, halted, fetch_cnt
   );

   modport slave (
      input  pc_src, jump, imm_ext, jump_addr, stall, halt,
      output pc_out, pc_plus4, pc_valid, halted, fetch_cnt
   );
endinterface

// File: rtl/pc_next_unit.sv
// PC register and next-PC selection for a single-cycle MIPS-32 datapath,
// with a one-cycle boot state, stall, sticky halt and a fetch counter.
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic           clk,
   input  logic           rst,
   pc_next_unit_if.slave  bus
);
   typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

   state_t           state, state_n;
   logic [31:0]      pc, pc_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      plus4;
   logic [31:0]      branch_target;
   logic [31:0]      jump_target;

   assign plus4         = pc + 32'd4;
   assign branch_target = plus4 + (bus.imm_ext << 2);
   assign jump_target   = {plus4[31:28], bus.jump_addr, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pc    <= RESET_PC;
         cnt   <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         cnt   <= cnt_n;
      end
   end

   // Inputs are only looked at in RUN, so X on them elsewhere cannot reach pc.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      cnt_n   = cnt;
      unique case (state)
         BOOT: state_n = RUN;
         RUN: begin
            if (bus.stall) begin
               pc_n = pc;
            end else if (bus.halt) begin
               state_n = HALTED;
            end else if (bus.jump) begin
               pc_n  = jump_target;
               cnt_n = cnt + CNT_W'(1);
            end else if (bus.pc_src) begin
               pc_n  = branch_target;
               cnt_n = cnt + CNT_W'(1);
            end else begin
               pc_n  = plus4;
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HALTED: state_n = HALTED;
         default: state_n = BOOT;
      endcase
   end

   assign bus.pc_out    = pc;
   assign bus.pc_plus4  = plus4;
   assign bus.pc_valid  = (state == RUN);
   assign bus.halted    = (state == HALTED);
   assign bus.fetch_cnt = cnt;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: vector table for the RUN sequence plus
// hand sequences for boot, halt persistence, async reset and counter wrap.
module tb_pc_next_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;

   always #5 clk = ~clk;

   pc_next_unit_if #(.CNT_W(32)) bus ();
   pc_next_unit_if #(.CNT_W(3))  bus2 ();

   pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(3)) dut_small (
      .clk(clk), .rst(rst2), .bus(bus2)
   );

   typedef struct {
      logic        stall;
      logic        halt;
      logic        jump;
      logic        pc_src;
      logic [31:0] imm;
      logic [25:0] ja;
      logic [31:0] pc;
      logic [31:0] cnt;
      logic        valid;
      logic        halted;
   } vec_t;

   vec_t vecs[18];
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mk(logic s, logic h, logic j, logic b,
                               logic [31:0] imm, logic [25:0] ja,
                               logic [31:0] pc, logic [31:0] cnt,
                               logic v, logic hd);
      vec_t r;
      r.stall = s; r.halt = h; r.jump = j; r.pc_src = b;
      r.imm = imm; r.ja = ja; r.pc = pc; r.cnt = cnt;
      r.valid = v; r.halted = hd;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic h, input logic j, input logic b,
                        input logic [31:0] imm, input logic [25:0] ja);
      bus.stall = s; bus.halt = h; bus.jump = j; bus.pc_src = b;
      bus.imm_ext = imm; bus.jump_addr = ja;
   endtask

   task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                              input logic v, input logic hd);
      check({tag, " pc_out"},    bus.pc_out, pc);
      check({tag, " pc_plus4"},  bus.pc_plus4, pc + 32'd4);
      check({tag, " fetch_cnt"}, bus.fetch_cnt, cnt);
      check({tag, " pc_valid"},  {31'd0, bus.pc_valid}, {31'd0, v});
      check({tag, " halted"},    {31'd0, bus.halted}, {31'd0, hd});
   endtask

   initial begin
      // RUN sequence starting from pc=0, cnt=0
      vecs[0]  = mk(0,0,0,0, 32'h0,          26'h0,  32'h0000_0004, 1,  1,0);
      vecs[1]  = mk(0,0,0,0, 32'h0,          26'h0,  32'h0000_0008, 2,  1,0);
      vecs[2]  = mk(0,0,0,0, 32'h0,          26'h0,  32'h0000_000C, 3,  1,0);
      vecs[3]  = mk(0,0,0,0, 32'h0,          26'h0,  32'h0000_0010, 4,  1,0);
      vecs[4]  = mk(0,0,1,0, 32'h0,          26'h40, 32'h0000_0100, 5,  1,0);
      vecs[5]  = mk(0,0,0,1, 32'hFFFF_FFFE,  26'h0,  32'h0000_00FC, 6,  1,0);
      vecs[6]  = mk(0,0,1,0, 32'h0,          26'h40, 32'h0000_0100, 7,  1,0);
      vecs[7]  = mk(0,0,0,1, 32'h3,          26'h0,  32'h0000_0110, 8,  1,0);
      vecs[8]  = mk(0,0,1,0, 32'h0,          26'h40, 32'h0000_0100, 9,  1,0);
      vecs[9]  = mk(0,0,0,1, 32'h03FF_FFCF,  26'h0,  32'h1000_0040, 10, 1,0);
      vecs[10] = mk(0,0,1,1, 32'h5,          26'h10, 32'h1000_0040, 11, 1,0);
      vecs[11] = mk(0,0,0,1, 32'h3BFF_FFEE,  26'h0,  32'hFFFF_FFFC, 12, 1,0);
      vecs[12] = mk(0,0,0,0, 32'h0,          26'h0,  32'h0000_0000, 13, 1,0);
      vecs[13] = mk(0,0,1,0, 32'h0,          26'h8,  32'h0000_0020, 14, 1,0);
      vecs[14] = mk(1,1,1,1, 32'h7,          26'h99, 32'h0000_0020, 14, 1,0);
      vecs[15] = mk(1,0,0,0, 32'h0,          26'h0,  32'h0000_0020, 14, 1,0);
      vecs[16] = mk(1,0,1,0, 32'h0,          26'h1,  32'h0000_0020, 14, 1,0);
      vecs[17] = mk(0,1,1,0, 32'h0,          26'h55, 32'h0000_0020, 14, 0,1);

      drive(0,0,0,0, 32'h0, 26'h0);
      bus2.stall = 0; bus2.halt = 0; bus2.jump = 0; bus2.pc_src = 0;
      bus2.imm_ext = '0; bus2.jump_addr = '0;

      repeat (2) @(posedge clk);
      #1;
      check_state("in reset", 32'h0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      // BOOT: redirect/halt ignored
      drive(1,1,1,1, 32'h10, 26'h3F);
      #1;
      check_state("boot", 32'h0, 0, 0, 0);
      @(posedge clk); #1;
      check_state("boot exit", 32'h0, 0, 1, 0);
      drive(0,0,0,0, 32'h0, 26'h0);

      for (int unsigned i = 0; i < 18; i++) begin
         drive(vecs[i].stall, vecs[i].halt, vecs[i].jump, vecs[i].pc_src, vecs[i].imm, vecs[i].ja);
         @(posedge clk); #1;
         check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].valid, vecs[i].halted);
      end

      // HALTED holds regardless of inputs
      for (int unsigned i = 0; i < 10; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 26'($urandom));
         @(posedge clk); #1;
         check_state($sformatf("halted%0d", i), 32'h20, 14, 0, 1);
      end

      // Reset out of HALTED, then move to 0x80 and pulse rst mid-cycle
      rst = 1'b1; #1;
      check_state("reset from halt", 32'h0, 0, 0, 0);
      drive(0,0,0,0, 32'h0, 26'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      drive(0,0,1,0, 32'h0, 26'h20);
      @(posedge clk); #1;
      check_state("at 0x80", 32'h80, 1, 1, 0);
      drive(0,0,0,0, 32'h0, 26'h0);
      #2;
      rst = 1'b1;
      #1;
      check_state("async reset", 32'h0, 0, 0, 0);
      #1;
      rst = 1'b0;

      // Narrow counter wraps from 7 to 0
      @(negedge clk);
      rst2 = 1'b0;
      @(posedge clk); #1;
      repeat (7) @(posedge clk);
      #1;
      check("cnt3 at max", {29'd0, bus2.fetch_cnt}, 32'd7);
      check("cnt3 pc", bus2.pc_out, 32'h1C);
      @(posedge clk); #1;
      check("cnt3 wrap", {29'd0, bus2.fetch_cnt}, 32'd0);
      check("cnt3 pc after wrap", bus2.pc_out, 32'h20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
